// File: rtl/serial_cmd_pkg.sv
// rtl/serial_cmd_pkg.sv - shared types and constants for the serial command sequencer
package serial_cmd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_WDATA,
        ST_WBUS,
        ST_TERM,
        ST_RBUS,
        ST_RESP_STAT,
        ST_RESP_DATA,
        ST_DRAIN
    } state_t;

    localparam logic [7:0] CMD_WRITE     = 8'h01;
    localparam logic [7:0] CMD_READ      = 8'h02;
    localparam logic [7:0] TERM_BYTE     = 8'hFF;

    localparam logic [7:0] STAT_OK       = 8'h00;
    localparam logic [7:0] STAT_BAD_CMD  = 8'h01;
    localparam logic [7:0] STAT_TIMEOUT  = 8'h02;
    localparam logic [7:0] STAT_BAD_TERM = 8'h03;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_WRITE) || (b == CMD_READ);
    endfunction

endpackage

// File: rtl/resp_byte_tx.sv
// rtl/resp_byte_tx.sv - serializes one 32-bit word into four MSB-first stream bytes
module resp_byte_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [31:0] i_word,
    input  logic        i_last,
    output logic [7:0]  o_tdata,
    output logic        o_tvalid,
    input  logic        i_tready,
    output logic        o_tlast,
    output logic        o_done
);
    logic [31:0] r_word;
    logic [1:0]  r_idx;
    logic        r_busy;
    logic        r_last;
    logic        w_fire;

    assign w_fire   = r_busy & i_tready;
    assign o_tdata  = r_word[31:24];
    assign o_tvalid = r_busy;
    assign o_tlast  = r_busy & r_last & (r_idx == 2'd3);
    assign o_done   = w_fire & (r_idx == 2'd3);

    // Load a word, then shift out one byte per accepted handshake; data holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word <= '0;
            r_idx  <= '0;
            r_busy <= 1'b0;
            r_last <= 1'b0;
        end else if (i_load) begin
            r_word <= i_word;
            r_idx  <= '0;
            r_busy <= 1'b1;
            r_last <= i_last;
        end else if (w_fire) begin
            r_word <= {r_word[23:0], 8'h00};
            r_idx  <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_cmd_sequencer.sv
// rtl/serial_cmd_sequencer.sv - byte-stream command decoder driving a request/ack word bus
module serial_cmd_sequencer
    import serial_cmd_pkg::*;
#(
    parameter int BUS_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    localparam int            TW       = $clog2(BUS_TIMEOUT) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(BUS_TIMEOUT - 1);

    state_t        r_state;
    state_t        w_next;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [15:0]   r_len;
    logic [1:0]    r_byte_cnt;
    logic [TW-1:0] r_tmo_cnt;
    logic [7:0]    r_status;
    logic          r_is_write;
    logic          r_first;
    logic          r_have_data;

    logic          w_rx_ready;
    logic          w_rx_fire;
    logic [15:0]   w_len_full;
    logic          w_tmo;
    logic          w_tx_load;
    logic          w_tx_tready;
    logic [7:0]    w_tx_tdata;
    logic          w_tx_tvalid;
    logic          w_tx_tlast;
    logic          w_tx_done;

    assign w_rx_ready = !rst && (r_state inside {ST_IDLE, ST_ADDR, ST_LEN, ST_WDATA, ST_TERM, ST_DRAIN});
    assign w_rx_fire  = s_axis_tvalid & w_rx_ready;
    assign w_len_full = {r_len[7:0], s_axis_tdata};
    assign w_tmo      = (r_tmo_cnt == TMO_LAST);

    assign s_axis_tready = w_rx_ready;
    assign bus_addr      = r_addr;
    assign bus_wdata     = r_wdata;

    assign w_tx_load   = (r_state == ST_RBUS) & bus_ack;
    assign w_tx_tready = m_axis_tready & (r_state == ST_RESP_DATA);

    resp_byte_tx u_resp_byte_tx (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_tx_load),
        .i_word   (bus_rdata),
        .i_last   (r_len == 16'd1),
        .o_tdata  (w_tx_tdata),
        .o_tvalid (w_tx_tvalid),
        .i_tready (w_tx_tready),
        .o_tlast  (w_tx_tlast),
        .o_done   (w_tx_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus bus and response stream outputs
    always_comb begin
        w_next        = r_state;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = 8'h00;
        m_axis_tlast  = 1'b0;
        bus_req       = 1'b0;
        bus_we        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rx_fire) begin
                    w_next = is_cmd(s_axis_tdata) ? ST_ADDR : ST_DRAIN;
                end
            end
            ST_ADDR: begin
                if (w_rx_fire && r_byte_cnt == 2'd3) begin
                    w_next = ST_LEN;
                end
            end
            ST_LEN: begin
                if (w_rx_fire && r_byte_cnt == 2'd1) begin
                    w_next = (r_is_write && w_len_full != 16'd0) ? ST_WDATA : ST_TERM;
                end
            end
            ST_WDATA: begin
                if (w_rx_fire && r_byte_cnt == 2'd3) begin
                    w_next = ST_WBUS;
                end
            end
            ST_WBUS: begin
                bus_req = 1'b1;
                bus_we  = 1'b1;
                if (bus_ack) begin
                    w_next = (r_len == 16'd1) ? ST_TERM : ST_WDATA;
                end else if (w_tmo) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_TERM: begin
                if (w_rx_fire) begin
                    if (s_axis_tdata != TERM_BYTE) begin
                        w_next = ST_DRAIN;
                    end else if (!r_is_write && r_len != 16'd0) begin
                        w_next = ST_RBUS;
                    end else begin
                        w_next = ST_RESP_STAT;
                    end
                end
            end
            ST_RBUS: begin
                bus_req = 1'b1;
                if (bus_ack) begin
                    w_next = r_first ? ST_RESP_STAT : ST_RESP_DATA;
                end else if (w_tmo) begin
                    w_next = ST_RESP_STAT;
                end
            end
            ST_RESP_STAT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = r_status;
                m_axis_tlast  = !r_have_data;
                if (m_axis_tready) begin
                    w_next = r_have_data ? ST_RESP_DATA : ST_IDLE;
                end
            end
            ST_RESP_DATA: begin
                m_axis_tvalid = w_tx_tvalid;
                m_axis_tdata  = w_tx_tdata;
                m_axis_tlast  = w_tx_tlast;
                if (w_tx_done) begin
                    w_next = (r_len == 16'd0) ? ST_IDLE : ST_RBUS;
                end
            end
            ST_DRAIN: begin
                if (w_rx_fire && s_axis_tlast && s_axis_tdata == TERM_BYTE) begin
                    w_next = ST_RESP_STAT;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Frame field assembly, address/word bookkeeping, bus timeout and status capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_len       <= '0;
            r_byte_cnt  <= '0;
            r_tmo_cnt   <= '0;
            r_status    <= STAT_OK;
            r_is_write  <= 1'b0;
            r_first     <= 1'b0;
            r_have_data <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rx_fire) begin
                        r_is_write  <= (s_axis_tdata == CMD_WRITE);
                        r_status    <= is_cmd(s_axis_tdata) ? STAT_OK : STAT_BAD_CMD;
                        r_byte_cnt  <= '0;
                        r_have_data <= 1'b0;
                        r_first     <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (w_rx_fire) begin
                        r_addr     <= {r_addr[23:0], s_axis_tdata};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                end
                ST_LEN: begin
                    if (w_rx_fire) begin
                        r_len      <= w_len_full;
                        r_byte_cnt <= (r_byte_cnt == 2'd1) ? 2'd0 : 2'd1;
                    end
                end
                ST_WDATA: begin
                    if (w_rx_fire) begin
                        r_wdata    <= {r_wdata[23:0], s_axis_tdata};
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                end
                ST_WBUS, ST_RBUS: begin
                    if (bus_ack) begin
                        r_addr    <= r_addr + 32'd4;
                        r_len     <= r_len - 16'd1;
                        r_tmo_cnt <= '0;
                        if (r_state == ST_RBUS) begin
                            r_have_data <= 1'b1;
                            r_first     <= 1'b0;
                        end
                    end else if (w_tmo) begin
                        r_status    <= STAT_TIMEOUT;
                        r_have_data <= 1'b0;
                        r_tmo_cnt   <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TW'(1);
                    end
                end
                ST_TERM: begin
                    if (w_rx_fire && s_axis_tdata != TERM_BYTE) begin
                        r_status <= STAT_BAD_TERM;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
